// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and its neighbours.
//   state_e   : fetch FSM state encoding
//   PC_*      : pc_src next-PC selector codes
//   MEMDST_PC : memory_datapath destination code that control drives during a fetch
//   sext8     : sign-extend an 8-bit branch offset to 16 bits
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StIssue = 2'd2
  } state_e;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JMP  = 2'b10;
  localparam logic [1:0] PC_HALT = 2'b11;

  localparam logic [2:0] MEMDST_PC = 3'b000;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_pc_next.sv
// Combinational next-PC selection applied at the instruction handshake.
// Ports:
//   pc          in  16  already-incremented PC
//   imm8        in  8   ir[7:0], signed branch offset
//   jump_target in  16  absolute target for a jump
//   pc_src      in  2   seq / branch / jump / halt
//   pc_next     out 16  selected next PC
module instruction_fetch_unit_pc_next
  import instruction_fetch_unit_pkg::*;
(
  input  logic [15:0] pc,
  input  logic [7:0]  imm8,
  input  logic [15:0] jump_target,
  input  logic [1:0]  pc_src,
  output logic [15:0] pc_next
);

  always_comb begin
    pc_next = pc;
    unique case (pc_src)
      PC_SEQ:  pc_next = pc;
      // Branch is relative to the incremented PC; the add wraps at 16 bits.
      PC_BR:   pc_next = pc + sext8(imm8);
      PC_JMP:  pc_next = jump_target;
      PC_HALT: pc_next = pc;
      default: pc_next = pc;
    endcase
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, reads instructions from memory_datapath and
// hands them to control over a valid/ready handshake.
// Ports:
//   clock, reset        clock (rising edge) and asynchronous active-high reset
//   fetch_en            permit fetching (sampled in IDLE and at the handshake)
//   mem_out             read data returned by memory_datapath
//   fetch_req           high while a read at pc is in progress
//   pc, ir              program counter and instruction register
//   opcode/ze_imm/ls_imm decoded fields of ir
//   instr_valid         ir holds a fresh instruction
//   instr_ready         control accepts the instruction
//   pc_src, jump_target next-PC selection, used only at the handshake
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned READ_LAT = 1,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic [DATA_W-1:0] mem_out,
  output logic              fetch_req,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [3:0]        opcode,
  output logic [DATA_W-1:0] ze_imm,
  output logic [DATA_W-1:0] ls_imm,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic [1:0]        pc_src,
  input  logic [DATA_W-1:0] jump_target
);

  localparam int unsigned CntW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CntW-1:0] LatLoad = CntW'(READ_LAT - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] pc_next;

  instruction_fetch_unit_pc_next u_pc_next (
    .pc          (pc_q),
    .imm8        (ir_q[7:0]),
    .jump_target (jump_target),
    .pc_src      (pc_src),
    .pc_next     (pc_next)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      lat_cnt_q <= '0;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    unique case (state_q)
      StIdle: begin
        if (fetch_en) begin
          state_d   = StFetch;
          lat_cnt_d = LatLoad;
        end
      end
      StFetch: begin
        // fetch_en is deliberately ignored here: a started fetch always completes.
        if (lat_cnt_q != '0) begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end else begin
          ir_d    = mem_out;
          pc_d    = pc_q + 16'd1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (instr_ready) begin
          pc_d = pc_next;
          if (pc_src == PC_HALT || !fetch_en) begin
            state_d = StIdle;
          end else begin
            state_d   = StFetch;
            lat_cnt_d = LatLoad;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs come from state only, so instr_ready never reaches an output.
  assign fetch_req   = (state_q == StFetch);
  assign instr_valid = (state_q == StIssue);

  assign pc     = pc_q;
  assign ir     = ir_q;
  assign opcode = ir_q[15:12];
  assign ze_imm = {8'b0, ir_q[7:0]};
  assign ls_imm = {6'b0, ir_q[7:0], 2'b00};

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench: dut_a (READ_LAT=1, RESET_PC=0000) covers sequencing, branch, jump, halt,
// backpressure and reset; dut_b (READ_LAT=3, RESET_PC=FFFF) covers latency and PC wrap.
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;

  logic        fetch_en, instr_ready;
  logic [1:0]  pc_src;
  logic [15:0] jump_target, mem_out;
  logic        fetch_req, instr_valid;
  logic [15:0] pc, ir, ze_imm, ls_imm;
  logic [3:0]  opcode;

  logic        fetch_en_b, instr_ready_b;
  logic [1:0]  pc_src_b;
  logic [15:0] jump_target_b, mem_out_b;
  logic        fetch_req_b, instr_valid_b;
  logic [15:0] pc_b, ir_b, ze_imm_b, ls_imm_b;
  logic [3:0]  opcode_b;

  logic [15:0] mem [256];

  int vectors = 0;
  int miscompares = 0;

  logic [33:0] got, want;

  always #5 clock = ~clock;

  assign mem_out   = mem[pc[7:0]];
  assign mem_out_b = (pc_b == 16'hFFFF) ? 16'hABCD : 16'h0000;

  instruction_fetch_unit #(
    .DATA_W   (16),
    .READ_LAT (1),
    .RESET_PC (16'h0000)
  ) dut_a (
    .clock       (clock),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .mem_out     (mem_out),
    .fetch_req   (fetch_req),
    .pc          (pc),
    .ir          (ir),
    .opcode      (opcode),
    .ze_imm      (ze_imm),
    .ls_imm      (ls_imm),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_src      (pc_src),
    .jump_target (jump_target)
  );

  instruction_fetch_unit #(
    .DATA_W   (16),
    .READ_LAT (3),
    .RESET_PC (16'hFFFF)
  ) dut_b (
    .clock       (clock),
    .reset       (reset),
    .fetch_en    (fetch_en_b),
    .mem_out     (mem_out_b),
    .fetch_req   (fetch_req_b),
    .pc          (pc_b),
    .ir          (ir_b),
    .opcode      (opcode_b),
    .ze_imm      (ze_imm_b),
    .ls_imm      (ls_imm_b),
    .instr_valid (instr_valid_b),
    .instr_ready (instr_ready_b),
    .pc_src      (pc_src_b),
    .jump_target (jump_target_b)
  );

  // Advance one clock; outputs are then sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    got  = {fetch_req, instr_valid, pc, ir};
    want = {1'b0, 1'b0, 16'h0000, 16'h0000};
    vectors++;
    if (got !== want) begin
      $display("FAIL reset_a got %h want %h", got, want); miscompares++;
    end
    got  = {fetch_req_b, instr_valid_b, pc_b, ir_b};
    want = {1'b0, 1'b0, 16'hFFFF, 16'h0000};
    vectors++;
    if (got !== want) begin
      $display("FAIL reset_b got %h want %h", got, want); miscompares++;
    end
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    fetch_en = 1'b1; instr_ready = 1'b1; pc_src = 2'b00;
    step();
    got = {fetch_req, instr_valid, pc, ir}; want = {1'b1, 1'b0, 16'h0000, 16'h0000};
    vectors++;
    if (got !== want) begin $display("FAIL seq_fetch0 got %h want %h", got, want); miscompares++; end
    step();
    got = {fetch_req, instr_valid, pc, ir}; want = {1'b0, 1'b1, 16'h0001, 16'h1203};
    vectors++;
    if (got !== want) begin $display("FAIL seq_issue0 got %h want %h", got, want); miscompares++; end
    vectors++;
    if ({opcode, ze_imm, ls_imm} !== {4'h1, 16'h0003, 16'h000C}) begin
      $display("FAIL seq_decode got %h want %h", {opcode, ze_imm, ls_imm},
               {4'h1, 16'h0003, 16'h000C});
      miscompares++;
    end
    step();
    got = {fetch_req, instr_valid, pc, ir}; want = {1'b1, 1'b0, 16'h0001, 16'h1203};
    vectors++;
    if (got !== want) begin $display("FAIL seq_fetch1 got %h want %h", got, want); miscompares++; end
    step();
    got = {fetch_req, instr_valid, pc, ir}; want = {1'b0, 1'b1, 16'h0002, 16'h2004};
    vectors++;
    if (got !== want) begin $display("FAIL seq_issue1 got %h want %h", got, want); miscompares++; end
  endtask

  // Jump to 0005, then branch -2 from the incremented PC, then a 0x80 offset (-128).
  task automatic test_branch();
    pc_src = 2'b10; jump_target = 16'h0005;
    step();
    got = {fetch_req, instr_valid, pc, ir}; want = {1'b1, 1'b0, 16'h0005, 16'h2004};
    vectors++;
    if (got !== want) begin $display("FAIL br_jmp5 got %h want %h", got, want); miscompares++; end
    pc_src = 2'b11;  // must be ignored while fetching
    step();
    got = {fetch_req, instr_valid, pc, ir}; want = {1'b0, 1'b1, 16'h0006, 16'h30FE};
    vectors++;
    if (got !== want) begin $display("FAIL br_issue got %h want %h", got, want); miscompares++; end
    pc_src = 2'b01;
    step();
    got = {fetch_req, instr_valid, pc, ir}; want = {1'b1, 1'b0, 16'h0004, 16'h30FE};
    vectors++;
    if (got !== want) begin $display("FAIL br_minus2 got %h want %h", got, want); miscompares++; end
    step();
    got = {fetch_req, instr_valid, pc, ir}; want = {1'b0, 1'b1, 16'h0005, 16'h5080};
    vectors++;
    if (got !== want) begin $display("FAIL br_mem4 got %h want %h", got, want); miscompares++; end
    step();
    got = {fetch_req, instr_valid, pc, ir}; want = {1'b1, 1'b0, 16'hFF85, 16'h5080};
    vectors++;
    if (got !== want) begin $display("FAIL br_minus128 got %h want %h", got, want); miscompares++; end
    step();
    got = {fetch_req, instr_valid, pc, ir}; want = {1'b0, 1'b1, 16'hFF86, 16'h6000};
    vectors++;
    if (got !== want) begin $display("FAIL br_issue2 got %h want %h", got, want); miscompares++; end
  endtask

  task automatic test_jump();
    pc_src = 2'b10; jump_target = 16'h0040;
    step();
    got = {fetch_req, instr_valid, pc, ir}; want = {1'b1, 1'b0, 16'h0040, 16'h6000};
    vectors++;
    if (got !== want) begin $display("FAIL jmp_fetch got %h want %h", got, want); miscompares++; end
    step();
    got = {fetch_req, instr_valid, pc, ir}; want = {1'b0, 1'b1, 16'h0041, 16'h7000};
    vectors++;
    if (got !== want) begin $display("FAIL jmp_issue got %h want %h", got, want); miscompares++; end
  endtask

  task automatic test_backpressure();
    instr_ready = 1'b0; pc_src = 2'b01; jump_target = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      step();
      got = {fetch_req, instr_valid, pc, ir}; want = {1'b0, 1'b1, 16'h0041, 16'h7000};
      vectors++;
      if (got !== want) begin
        $display("FAIL bp_hold%0d got %h want %h", i, got, want); miscompares++;
      end
    end
    instr_ready = 1'b1; pc_src = 2'b10; jump_target = 16'h0080;
    step();
    got = {fetch_req, instr_valid, pc, ir}; want = {1'b1, 1'b0, 16'h0080, 16'h7000};
    vectors++;
    if (got !== want) begin $display("FAIL bp_accept got %h want %h", got, want); miscompares++; end
    step();
    got = {fetch_req, instr_valid, pc, ir}; want = {1'b0, 1'b1, 16'h0081, 16'h8000};
    vectors++;
    if (got !== want) begin $display("FAIL bp_next got %h want %h", got, want); miscompares++; end
  endtask

  task automatic test_halt();
    pc_src = 2'b11; fetch_en = 1'b1;
    step();
    got = {fetch_req, instr_valid, pc, ir}; want = {1'b0, 1'b0, 16'h0081, 16'h8000};
    vectors++;
    if (got !== want) begin $display("FAIL halt_idle got %h want %h", got, want); miscompares++; end
    fetch_en = 1'b0; pc_src = 2'b00;
    for (int i = 0; i < 2; i++) begin
      step();
      got = {fetch_req, instr_valid, pc, ir}; want = {1'b0, 1'b0, 16'h0081, 16'h8000};
      vectors++;
      if (got !== want) begin
        $display("FAIL halt_stay%0d got %h want %h", i, got, want); miscompares++;
      end
    end
    fetch_en = 1'b1;
    step();
    got = {fetch_req, instr_valid, pc, ir}; want = {1'b1, 1'b0, 16'h0081, 16'h8000};
    vectors++;
    if (got !== want) begin $display("FAIL halt_resume got %h want %h", got, want); miscompares++; end
    fetch_en = 1'b0;  // dropped mid-fetch: fetch still completes
    step();
    got = {fetch_req, instr_valid, pc, ir}; want = {1'b0, 1'b1, 16'h0082, 16'h9000};
    vectors++;
    if (got !== want) begin $display("FAIL halt_nodrop got %h want %h", got, want); miscompares++; end
    step();
    got = {fetch_req, instr_valid, pc, ir}; want = {1'b0, 1'b0, 16'h0082, 16'h9000};
    vectors++;
    if (got !== want) begin $display("FAIL seq_to_idle got %h want %h", got, want); miscompares++; end
  endtask

  task automatic test_reset_mid_fetch();
    fetch_en = 1'b1;
    step();
    got = {fetch_req, instr_valid, pc, ir}; want = {1'b1, 1'b0, 16'h0082, 16'h9000};
    vectors++;
    if (got !== want) begin $display("FAIL rst_pre got %h want %h", got, want); miscompares++; end
    #2;
    reset = 1'b1;
    #1;
    got = {fetch_req, instr_valid, pc, ir}; want = {1'b0, 1'b0, 16'h0000, 16'h0000};
    vectors++;
    if (got !== want) begin $display("FAIL rst_async got %h want %h", got, want); miscompares++; end
    step();
    got = {fetch_req, instr_valid, pc, ir}; want = {1'b0, 1'b0, 16'h0000, 16'h0000};
    vectors++;
    if (got !== want) begin $display("FAIL rst_held got %h want %h", got, want); miscompares++; end
    reset = 1'b0; fetch_en = 1'b0;
  endtask

  task automatic test_wrap_latency();
    fetch_en_b = 1'b1; instr_ready_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      fetch_en_b = 1'b0;
      got = {fetch_req_b, instr_valid_b, pc_b, ir_b}; want = {1'b1, 1'b0, 16'hFFFF, 16'h0000};
      vectors++;
      if (got !== want) begin
        $display("FAIL lat_req%0d got %h want %h", i, got, want); miscompares++;
      end
    end
    step();
    got = {fetch_req_b, instr_valid_b, pc_b, ir_b}; want = {1'b0, 1'b1, 16'h0000, 16'hABCD};
    vectors++;
    if (got !== want) begin $display("FAIL wrap_issue got %h want %h", got, want); miscompares++; end
    step();
    got = {fetch_req_b, instr_valid_b, pc_b, ir_b}; want = {1'b0, 1'b1, 16'h0000, 16'hABCD};
    vectors++;
    if (got !== want) begin $display("FAIL wrap_hold got %h want %h", got, want); miscompares++; end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h1203;
    mem[8'h01] = 16'h2004;
    mem[8'h04] = 16'h5080;
    mem[8'h05] = 16'h30FE;
    mem[8'h40] = 16'h7000;
    mem[8'h80] = 16'h8000;
    mem[8'h81] = 16'h9000;
    mem[8'h85] = 16'h6000;

    reset = 1'b1;
    fetch_en = 1'b0; instr_ready = 1'b1; pc_src = 2'b00; jump_target = 16'h0000;
    fetch_en_b = 1'b0; instr_ready_b = 1'b0; pc_src_b = 2'b00; jump_target_b = 16'h0000;

    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_backpressure();
    test_halt();
    test_reset_mid_fetch();
    test_wrap_latency();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
